data_memory_arbiter: RTL and testbench

//  Shares the single-port 8-bit data memory between two requesters (0: CPU datapath, 1: DMA/sort engine).

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter_2.sv | 24 ++
 rtl/data_memory_arbiter.sv | 128 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF     = 8;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned PROT_LIMIT_DEF = 7;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request wins; on contention the requester that
// did not win last time is chosen.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    grant  = 2'b00;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_winner;
      default: winner = 1'b0;
    endcase
    if (req != 2'b00) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data memory between the CPU (0) and DMA/sort engine (1).
// Optional write protection of low addresses for requester 1: define MEM_PROTECT_EN.
module data_memory_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned PROT_LIMIT = PROT_LIMIT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        err,
  output logic              memWrite,
  output logic              memRead,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] escreveDado,
  input  logic [DATA_W-1:0] leDado
);

  state_e            state_q, state_d;
  logic              last_q;
  logic              cur_q;
  logic              cur_read_q;
  logic [1:0]        arb_grant;
  logic              arb_winner;
  logic              hs;
  logic              sel_we;
  logic              blocked;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter_2 u_rr (
    .req         (req),
    .last_winner (last_q),
    .grant       (arb_grant),
    .winner      (arb_winner)
  );

  assign sel_we    = we[arb_winner];
  assign sel_addr  = arb_winner ? addr1 : addr0;
  assign sel_wdata = arb_winner ? wdata1 : wdata0;

  always_comb begin
    state_d = state_q;
    gnt     = 2'b00;
    unique case (state_q)
      IDLE: begin
        gnt = arb_grant;
        if (hs) state_d = ACCESS;
      end
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign hs = |(req & gnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cur_q       <= 1'b0;
      cur_read_q  <= 1'b0;
      memWrite    <= 1'b0;
      memRead     <= 1'b0;
      endereco    <= '0;
      escreveDado <= '0;
      ack         <= 2'b00;
      rdata       <= '0;
    end else begin
      state_q <= state_d;
      ack     <= 2'b00;
      if (state_q == IDLE && hs) begin
        last_q      <= arb_winner;
        cur_q       <= arb_winner;
        cur_read_q  <= ~sel_we;
        endereco    <= sel_addr;
        escreveDado <= sel_wdata;
        memRead     <= ~sel_we;
        // A blocked write still runs the full handshake, it just never strobes the memory.
        memWrite    <= sel_we & ~blocked;
      end else if (state_q == ACCESS) begin
        if (cur_read_q) rdata <= leDado;
        ack[cur_q] <= 1'b1;
        memRead    <= 1'b0;
        memWrite   <= 1'b0;
      end
    end
  end

`ifdef MEM_PROTECT_EN
  localparam logic [ADDR_W-1:0] ProtLimitA = ADDR_W'(PROT_LIMIT);

  logic       cur_err_q;
  logic [1:0] err_q;

  assign blocked = (arb_winner == REQ_DMA) && sel_we && (addr1 < ProtLimitA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_err_q <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      err_q <= 2'b00;
      if (state_q == IDLE && hs) begin
        cur_err_q <= blocked;
      end else if (state_q == ACCESS) begin
        err_q[cur_q] <= cur_err_q;
      end
    end
  end

  assign err = err_q;
`else
  assign blocked = 1'b0;
  assign err     = 2'b00;
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomized and directed self-checking bench for data_memory_arbiter with a simple
// behavioural data_memory and a transaction-level reference model.
module tb_data_memory_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] we = 2'b00;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, ack, err;
  logic [7:0] rdata, endereco, escreveDado, leDado;
  logic       memWrite, memRead;

  int checks = 0;
  int errors = 0;

  data_memory_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt         (gnt),
    .ack         (ack),
    .rdata       (rdata),
    .err         (err),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .endereco    (endereco),
    .escreveDado (escreveDado),
    .leDado      (leDado)
  );

  always #5 clock = ~clock;

  // Behavioural data_memory: reads on negedge, writes on posedge.
  logic [7:0] mem_arr [256];
  always @(negedge clock) if (memRead === 1'b1) leDado <= mem_arr[endereco];
  always @(posedge clock) if (memWrite === 1'b1) mem_arr[endereco] <= escreveDado;

  int mw_cnt = 0;
  always @(posedge clock) if (memWrite === 1'b1) mw_cnt++;

  // Reference model: transaction view of the shared memory.
  logic [7:0] ref_mem [256];
  bit         m_busy, m_last, m_who, m_we, m_prot;
  logic [7:0] m_addr, m_data;
  logic [1:0] e_ack, e_err, last_hs;
  logic [7:0] e_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_gnt();
    if (m_busy || req == 2'b00) return 2'b00;
    if (req == 2'b11) return m_last ? 2'b01 : 2'b10;
    return req;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1; e_ack = 0; e_err = 0; e_rdata = 0; last_hs = 0;
  endtask

  // One clock: inputs already driven; check combinational/memory side, then the edge.
  task automatic cycle();
    logic [1:0] eg, hs;
    bit w, c_we, c_prot;
    logic [7:0] c_addr, c_data;
    #1;
    eg = exp_gnt();
    check("gnt", gnt, eg);
    check("memWrite", memWrite, m_busy && m_we && !m_prot);
    check("memRead", memRead, m_busy && !m_we);
    if (m_busy) check("endereco", endereco, m_addr);
    hs = req & eg;
    w = hs[1];
    c_we = we[w];
    c_addr = w ? addr1 : addr0;
    c_data = w ? wdata1 : wdata0;
`ifdef MEM_PROTECT_EN
    c_prot = w && c_we && (c_addr < 8'd7);
`else
    c_prot = 0;
`endif
    @(posedge clock);
    #1;
    e_ack = 0;
    e_err = 0;
    if (m_busy) begin
      e_ack[m_who] = 1'b1;
      e_err[m_who] = m_prot;
      if (m_we && !m_prot) ref_mem[m_addr] = m_data;
      else if (!m_we) e_rdata = ref_mem[m_addr];
      m_busy = 0;
    end else if (hs != 2'b00) begin
      m_busy = 1; m_who = w; m_last = w; m_we = c_we;
      m_addr = c_addr; m_data = c_data; m_prot = c_prot;
    end
    check("ack", ack, e_ack);
    check("err", err, e_err);
    check("rdata", rdata, e_rdata);
    last_hs = hs;
  endtask

  task automatic set_req(input int r, input bit w, input logic [7:0] a, input logic [7:0] d);
    req[r] = 1'b1;
    we[r]  = w;
    if (r == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
  endtask

  // Issue one access and run until its ack is visible.
  task automatic do_op(input int r, input bit w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    set_req(r, w, a, d);
    last_hs = 0;
    while (last_hs[r] == 1'b0 && n < 8) begin cycle(); n++; end
    check("handshake_timeout", 32'(last_hs[r]), 32'd1);
    req[r] = 1'b0;
    cycle();
  endtask

  initial begin
    logic [7:0] prior;
    int mw0, ng, na;
    logic [1:0] win_seq [8];
    logic [7:0] rd_seq [8];

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = (i < 7) ? 8'(i + 1) : 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_ack", ack, 2'b00);
    check("rst_err", err, 2'b00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_endereco", endereco, 8'h00);
    check("rst_escreveDado", escreveDado, 8'h00);
    check("rst_memWrite", memWrite, 1'b0);

    // CPU read of address 3
    do_op(0, 1'b0, 8'd3, 8'h00);
    check("read3_ack", ack, 2'b01);
    check("read3_rdata", rdata, 8'd4);
    cycle();

    // DMA write 10 then read back; exactly one memWrite cycle
    mw0 = mw_cnt;
    do_op(1, 1'b1, 8'd10, 8'hA5);
    check("wr10_memwrite_cycles", mw_cnt - mw0, 1);
    do_op(1, 1'b0, 8'd10, 8'h00);
    check("rd10_rdata", rdata, 8'hA5);
    cycle();

    // Both held, reading 0 and 1: alternate grants
    set_req(0, 1'b0, 8'd0, 8'h00);
    set_req(1, 1'b0, 8'd1, 8'h00);
    ng = 0;
    na = 0;
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (last_hs != 2'b00) begin win_seq[ng] = last_hs; ng++; end
      if (ack != 2'b00) begin rd_seq[na] = rdata; na++; end
    end
    req = 2'b00;
    check("rr_grants", ng, 4);
    check("rr_acks", na, 4);
    for (int k = 0; k < 4; k++) begin
      check("rr_order", win_seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_rdata", rd_seq[k], (k % 2 == 0) ? 8'd1 : 8'd2);
    end
    cycle();

    // Reset during ACCESS of a write aborts it
    prior = ref_mem[20];
    set_req(1, 1'b1, 8'd20, 8'h3C);
    cycle();
    check("abort_hs", last_hs, 2'b10);
    req = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    check("abort_memWrite", memWrite, 1'b0);
    check("abort_ack", ack, 2'b00);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    cycle();
    check("abort_no_ack", ack, 2'b00);
    do_op(0, 1'b0, 8'd20, 8'h00);
    check("abort_prior", rdata, prior);
    cycle();

    // Low-address write by requester 1
    do_op(1, 1'b1, 8'd2, 8'hFF);
`ifdef MEM_PROTECT_EN
    check("prot_err", err, 2'b10);
`else
    check("prot_err", err, 2'b00);
`endif
    check("prot_ack", ack, 2'b10);
    do_op(0, 1'b0, 8'd2, 8'h00);
`ifdef MEM_PROTECT_EN
    check("prot_read", rdata, 8'd3);
`else
    check("prot_read", rdata, 8'hFF);
`endif
    do_op(0, 1'b1, 8'd2, 8'hFF);
    check("cpu_wr_err", err, 2'b00);
    do_op(1, 1'b0, 8'd2, 8'h00);
    check("cpu_wr_read", rdata, 8'hFF);
    cycle();

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (last_hs[r]) req[r] = 1'b0;
        if (!req[r]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(r, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom));
        end else if (!m_busy && $urandom_range(0, 9) == 0) begin
          req[r] = 1'b0;
        end
      end
      cycle();
    end
    req = 2'b00;
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
